// File: rtl/uart_cmd_parser_if.sv
// Byte-stream, command and error signals between the UART receiver, the command parser and the register block.
// The parser connects through modport master; the receiver/consumer side uses modport slave.
interface uart_cmd_parser_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [15:0]           cmd_wdata;
  logic                  err_pulse;
  logic [1:0]            err_code;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output rx_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_pulse, err_code
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  rx_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_pulse, err_code
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/HDR/DHI/DLO[/CSUM] byte frames into register-access commands with inter-byte timeout.
// Define CMD_CHECKSUM_EN to add the trailing XOR checksum byte (5-byte frames).
module uart_cmd_parser #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  uart_cmd_parser_if.master bus
);
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {S_SYNC, S_HDR, S_DHI, S_DLO, S_CSUM, S_OUT} state_e;
`else
  typedef enum logic [2:0] {S_SYNC, S_HDR, S_DHI, S_DLO, S_OUT} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [1:0]            err_code_q, err_code_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]            hdr_q, hdr_d;
`endif

  logic rx_ready_c, byte_acc_c, cmd_acc_c, in_frame_c, expired_c;

  assign rx_ready_c = ena & (state_q != S_OUT);
  assign byte_acc_c = rx_ready_c & bus.rx_valid;
  assign cmd_acc_c  = ena & valid_q & bus.cmd_ready;
  assign in_frame_c = (state_q != S_SYNC) && (state_q != S_OUT);
  // A byte arriving on the last allowed cycle still wins over the timeout.
  assign expired_c  = in_frame_c & ~byte_acc_c & (cnt_q == CNT_LAST);

  // Next-state, field capture, timeout and error logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef CMD_CHECKSUM_EN
    hdr_d       = hdr_q;
`endif

    if (in_frame_c) cnt_d = cnt_q + CNT_W'(1);
    if (byte_acc_c) cnt_d = '0;

    case (state_q)
      S_SYNC: begin
        if (byte_acc_c && (bus.rx_data == SYNC_BYTE)) state_d = S_HDR;
      end
      S_HDR: begin
        if (byte_acc_c) begin
          write_d = bus.rx_data[7];
          addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
`ifdef CMD_CHECKSUM_EN
          hdr_d   = bus.rx_data;
`endif
          state_d = S_DHI;
        end
      end
      S_DHI: begin
        if (byte_acc_c) begin
          wdata_d[15:8] = bus.rx_data;
          state_d       = S_DLO;
        end
      end
      S_DLO: begin
        if (byte_acc_c) begin
          wdata_d[7:0] = bus.rx_data;
`ifdef CMD_CHECKSUM_EN
          state_d      = S_CSUM;
`else
          state_d      = S_OUT;
          valid_d      = 1'b1;
`endif
        end
      end
`ifdef CMD_CHECKSUM_EN
      S_CSUM: begin
        if (byte_acc_c) begin
          if (bus.rx_data == (hdr_q ^ wdata_q[15:8] ^ wdata_q[7:0])) begin
            state_d = S_OUT;
            valid_d = 1'b1;
          end else begin
            state_d     = S_SYNC;
            err_pulse_d = 1'b1;
            err_code_d  = 2'b10;
          end
        end
      end
`endif
      S_OUT: begin
        if (cmd_acc_c) begin
          valid_d = 1'b0;
          state_d = S_SYNC;
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (expired_c) begin
      state_d     = S_SYNC;
      err_pulse_d = 1'b1;
      err_code_d  = 2'b01;
    end

    if (state_d == S_SYNC) cnt_d = '0;
  end

  // All registers freeze while ena is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'b00;
`ifdef CMD_CHECKSUM_EN
      hdr_q       <= '0;
`endif
    end else if (ena) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef CMD_CHECKSUM_EN
      hdr_q       <= hdr_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_c;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_write = write_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_wdata = wdata_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed vector table, hand-written corner sequences,
// and randomized frames checked every cycle against a frame-level byte-queue reference model.
module tb_uart_cmd_parser;
  localparam int unsigned AW   = 4;
  localparam int unsigned TOUT = 16;
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef CMD_CHECKSUM_EN
  localparam int unsigned FLEN = 5;
`else
  localparam int unsigned FLEN = 4;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic ena;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_WIDTH(AW)) bus ();

  uart_cmd_parser #(
    .ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collects frame bytes in a queue and applies the frame rules per accepted byte.
  logic [7:0]    frame[$];
  int            m_gap;
  bit            m_pending;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata;
  logic          m_err_pulse;
  logic [1:0]    m_err_code;
  bit            m_ok;

  always @(posedge clk) begin
    if (!reset_n) begin
      frame.delete();
      m_gap = 0; m_pending = 0; m_write = 0; m_addr = '0; m_wdata = '0;
      m_err_pulse = 0; m_err_code = 2'b00;
    end else if (ena) begin
      m_err_pulse = 0;
      if (m_pending) begin
        if (bus.cmd_ready) m_pending = 0;
      end else if (bus.rx_valid) begin
        m_gap = 0;
        if (frame.size() == 0) begin
          if (bus.rx_data == SYNC) frame.push_back(bus.rx_data);
        end else begin
          frame.push_back(bus.rx_data);
          if (frame.size() == 2) begin m_write = frame[1][7]; m_addr = frame[1][AW-1:0]; end
          if (frame.size() == 3) m_wdata[15:8] = frame[2];
          if (frame.size() == 4) m_wdata[7:0]  = frame[3];
          if (frame.size() == FLEN) begin
`ifdef CMD_CHECKSUM_EN
            m_ok = (frame[4] == (frame[1] ^ frame[2] ^ frame[3]));
`else
            m_ok = 1;
`endif
            if (m_ok) m_pending = 1;
            else begin m_err_pulse = 1; m_err_code = 2'b10; end
            frame.delete();
          end
        end
      end else if (frame.size() != 0) begin
        if (m_gap == TOUT - 1) begin
          m_err_pulse = 1; m_err_code = 2'b01; m_gap = 0;
          frame.delete();
        end else m_gap++;
      end
    end
  end

  function automatic logic [25:0] dut_out();
    return {bus.rx_ready, bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata,
            bus.err_pulse, bus.err_code};
  endfunction

  function automatic logic [25:0] model_out();
    return {ena & ~m_pending, m_pending, m_write, m_addr, m_wdata, m_err_pulse, m_err_code};
  endfunction

  // Advance one clock and compare every output against the model.
  task automatic step();
    @(posedge clk);
    #1;
    check("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  typedef struct {
    logic rst_n, en, rv; logic [7:0] rd; logic cr;
    logic rr, cv, w; logic [AW-1:0] a; logic [15:0] wd; logic ep; logic [1:0] ec;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, en, rv, input logic [7:0] rd, input logic cr,
                              input logic rr, cv, w, input logic [AW-1:0] a,
                              input logic [15:0] wd, input logic ep, input logic [1:0] ec);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.rv = rv; v.rd = rd; v.cr = cr;
    v.rr = rr; v.cv = cv; v.w = w; v.a = a; v.wd = wd; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  // Random frame byte: waits (bounded) until the model says the byte is taken, then a random gap.
  task automatic rnd_push(input logic [7:0] b);
    bit acc;
    int n;
    int g;
    acc = 0; n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    do begin
      ena           = ($urandom_range(0, 7) != 0);
      bus.cmd_ready = 1'($urandom_range(0, 1));
      acc           = ena && !m_pending;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_bound: byte %h not taken within 200 cycles", b);
    end
    bus.rx_valid = 1'b0;
    g = ($urandom_range(0, 39) == 0) ? int'(TOUT) + 1 : int'($urandom_range(0, 3));
    repeat (g) begin
      ena           = ($urandom_range(0, 7) != 0);
      bus.cmd_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] h, dh, dl, cs;
    reset_n = 1'b0; ena = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.cmd_ready = 1'b0;

    // Directed vectors: inputs for one cycle, outputs expected just after that edge.
    vecs.push_back(mk(0,1,0,8'h00,0, 1,0,0,4'h0,16'h0000,0,2'b00));
    vecs.push_back(mk(1,1,1,8'hA5,1, 1,0,0,4'h0,16'h0000,0,2'b00));
    vecs.push_back(mk(1,1,1,8'h83,1, 1,0,1,4'h3,16'h0000,0,2'b00));
    vecs.push_back(mk(1,1,1,8'h12,1, 1,0,1,4'h3,16'h1200,0,2'b00));
`ifdef CMD_CHECKSUM_EN
    vecs.push_back(mk(1,1,1,8'h34,1, 1,0,1,4'h3,16'h1234,0,2'b00));
    vecs.push_back(mk(1,1,1,8'hA5,1, 0,1,1,4'h3,16'h1234,0,2'b00));
`else
    vecs.push_back(mk(1,1,1,8'h34,1, 0,1,1,4'h3,16'h1234,0,2'b00));
`endif
    vecs.push_back(mk(1,1,0,8'h00,1, 1,0,1,4'h3,16'h1234,0,2'b00));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,0,1,4'h3,16'h1234,0,2'b00));
    vecs.push_back(mk(1,0,1,8'hA5,0, 0,0,1,4'h3,16'h1234,0,2'b00));
    vecs.push_back(mk(1,1,1,8'hA5,0, 1,0,1,4'h3,16'h1234,0,2'b00));
    vecs.push_back(mk(0,1,1,8'h83,0, 1,0,0,4'h0,16'h0000,0,2'b00));

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n; ena = vecs[i].en;
      bus.rx_valid = vecs[i].rv; bus.rx_data = vecs[i].rd; bus.cmd_ready = vecs[i].cr;
      step();
      check($sformatf("vec%0d", i), 32'(dut_out()),
            32'({vecs[i].rr, vecs[i].cv, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].ep, vecs[i].ec}));
    end
    reset_n = 1'b1; ena = 1'b1; bus.rx_valid = 1'b0; bus.cmd_ready = 1'b0;
    step();

    // Leading junk is dropped silently; command holds under back-pressure.
    send(8'h00); send(8'hFF);
    check("junk_no_err", {30'd0, bus.err_code}, 32'd0);
    send(8'hA5); send(8'h05); send(8'hBE); send(8'hEF);
`ifdef CMD_CHECKSUM_EN
    send(8'h54);
`endif
    check("hold_fields", {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata},
          {1'b1, 1'b0, 4'h5, 16'hBEEF});
    repeat (10) begin
      step();
      check("hold_valid", {bus.cmd_valid, bus.rx_ready}, 2'b10);
    end
    bus.cmd_ready = 1'b1;
    #1 check("ready_low_in_accept", 32'(bus.rx_ready), 32'd0);
    step();
    check("after_accept", {bus.cmd_valid, bus.rx_ready}, 2'b01);
    bus.cmd_ready = 1'b0;

    // Timeout fires on exactly the TOUT-th idle cycle, then a fresh frame decodes.
    send(8'hA5); send(8'h83);
    repeat (TOUT - 1) step();
    check("no_early_timeout", 32'(bus.err_pulse), 32'd0);
    step();
    check("timeout_pulse", {bus.err_pulse, bus.err_code}, {1'b1, 2'b01});
    step();
    check("timeout_single", {bus.err_pulse, bus.err_code}, {1'b0, 2'b01});
    bus.cmd_ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h07);
`ifdef CMD_CHECKSUM_EN
    send(8'h06);
`endif
    check("post_timeout_cmd", {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata},
          {1'b1, 1'b0, 4'h1, 16'h0007});
    step();
    bus.cmd_ready = 1'b0;

`ifdef CMD_CHECKSUM_EN
    send(8'hA5); send(8'h83); send(8'h12); send(8'h34); send(8'h00);
    check("csum_err", {bus.cmd_valid, bus.err_pulse, bus.err_code}, {1'b0, 1'b1, 2'b10});
    step();
    check("csum_err_hold", {bus.err_pulse, bus.err_code}, {1'b0, 2'b10});
`endif

    // ena low mid-frame: no accepts, no timeout progress.
    send(8'hA5); send(8'h83);
    ena = 1'b0; bus.rx_valid = 1'b1; bus.rx_data = 8'h12;
    repeat (20) begin
      step();
      check("ena_low_ready", {bus.rx_ready, bus.err_pulse}, 2'b00);
    end
    ena = 1'b1;
    send(8'h12); send(8'h34);
`ifdef CMD_CHECKSUM_EN
    send(8'hA5);
`endif
    check("ena_resume_cmd", {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata},
          {1'b1, 1'b1, 4'h3, 16'h1234});

    // Reset while a command is pending.
    reset_n = 1'b0;
    step();
    check("reset_pending", 32'(dut_out()), 32'({1'b1, 25'd0}));
    reset_n = 1'b1;
    step();

    // Randomized frames, some junk-prefixed, some with bad checksums or long gaps.
    for (int f = 0; f < 300; f++) begin
      repeat ($urandom_range(0, 2)) rnd_push(8'($urandom));
      h = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
      cs = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (h ^ dh ^ dl);
      rnd_push(SYNC); rnd_push(h); rnd_push(dh); rnd_push(dl);
`ifdef CMD_CHECKSUM_EN
      rnd_push(cs);
`else
      if (cs == 8'hFF) rnd_push(cs);
`endif
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0; step(); reset_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
